tl_inflight_tracker: RTL and testbench
======================================

TL_INFLIGHT_TRACKER -- requirements
Module: tl_inflight_tracker

Interface
REQ-001 SHALL have parameter SOURCE_BITS, default 7, width of a_source/d_source (2^SOURCE_BITS tracked IDs).
REQ-002 SHALL have parameter ADDR_BITS, default 25, width of a_address.
REQ-003 SHALL have parameter BEAT_BYTES, default 4, data bus bytes per beat (power of 2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, watchdog limit (used only under REQ-030).
REQ-005 clock  in  1  sole clock, all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 a_valid, a_ready  in  1 each  TileLink A handshake (observed, not driven).
REQ-008 a_opcode  in  3  A opcode (0 PutFullData, 1 PutPartialData, 4 Get).
REQ-009 a_size  in  4  log2 bytes of transfer.
REQ-010 a_source  in  SOURCE_BITS  request ID.
REQ-011 a_address  in  ADDR_BITS  byte address.
REQ-012 d_valid, d_ready  in  1 each  TileLink D handshake.
REQ-013 d_opcode  in  3  D opcode (0 AccessAck, 1 AccessAckData).
REQ-014 d_size  in  4; d_source  in  SOURCE_BITS.
REQ-015 err_clear  in  1  synchronous clear of err.
REQ-016 inflight_count  out  SOURCE_BITS+1  number of outstanding IDs.
REQ-017 err  out  4  sticky flags: [0] duplicate A source, [1] D for unknown source, [2] A address unaligned to a_size, [3] timeout.

Function
REQ-018 A fire = a_valid&a_ready; D fire = d_valid&d_ready; only fire cycles update state.
REQ-019 Beats per message = 1 if size<=log2(BEAT_BYTES) else 2^(size-log2(BEAT_BYTES)); A carries data for opcode 0/1, D for opcode 1.
REQ-020 Separate A and D beat counters; first beat when counter==0, last beat when counter==beats-1, then counter wraps to 0.
REQ-021 A first beat: set pending[a_source]; if already set and not cleared this cycle by D last beat, set err[0].
REQ-022 A first beat with a_address[size-1:0]!=0 sets err[2]; non-first beats not checked.
REQ-023 D last beat: clear pending[d_source]; if pending[d_source] was 0 at start of cycle, set err[1] and leave bitmap unchanged.
REQ-024 Same-cycle A first beat and D last beat on the same ID: D checked against pre-cycle bitmap; if valid, net result pending=1, no error.
REQ-025 Same-cycle set/clear on different IDs: inflight_count changes by net (+1,-1 => unchanged).
REQ-026 inflight_count registered, equal to popcount(pending) one cycle after any fire; never wraps (max 2^SOURCE_BITS).
REQ-027 err bits sticky until err_clear; err_clear and new error in same cycle: error wins.

Reset
REQ-028 On reset_n low, asynchronously: pending=0, beat counters=0, inflight_count=0, err=0, watchdog=0.
REQ-029 Reset mid-burst discards partial beats; first post-reset fire is treated as a first beat.

Configuration
REQ-030 Macro TL_INFLIGHT_TIMEOUT_EN defined: watchdog counts cycles with inflight_count!=0 and no D fire, resets to 0 on D fire or count==0, sets err[3] when reaching TIMEOUT_CYCLES and saturates; undefined: no watchdog logic, err[3] tied 0.

Structure
REQ-031 Shared package tl_trk_pkg SHALL hold opcode constants, err bit index constants and beat-count function.
REQ-032 One sub-module tl_beat_counter (size/opcode in, first/last out), instantiated once for A and once for D.

Verification
REQ-033 Get src 5 addr 0x40 size 2, then AccessAck src 5 -> inflight_count 1 then 0, err=0.
REQ-034 PutFullData size 4 (4 beats) src 3, Get src 3 before AccessAck -> err[0]=1 on the Get; beats 2-4 of the Put cause no error.
REQ-035 AccessAckData src 9 with nothing pending -> err[1]=1, inflight_count stays 0; err_clear -> err=0 next cycle.
REQ-036 Get addr 0x42 size 2 -> err[2]=1; same cycle D last beat src 7 (pending) and A Get src 7 -> no error, count unchanged.
REQ-037 With TL_INFLIGHT_TIMEOUT_EN, TIMEOUT_CYCLES=16, Get src 1, no D for 16 cycles -> err[3]=1; without macro err[3] stays 0.
REQ-038 reset_n low mid 4-beat AccessAckData -> all outputs 0 immediately; next single-beat AccessAck src 0 -> err[1]=1.

Source files
------------

// File: rtl/tl_inflight_tracker_pkg.sv
// rtl/tl_inflight_tracker_pkg.sv - shared constants and beat-count helper for the TileLink in-flight tracker
//
// Package tl_trk_pkg:
//   - A/D opcode constants
//   - bit positions inside the err flag vector
//   - beat_count(): number of bus beats a message occupies
package tl_trk_pkg;

    // A channel opcodes
    localparam logic [2:0] OP_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] OP_GET              = 3'd4;

    // D channel opcodes
    localparam logic [2:0] OP_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA  = 3'd1;

    // err vector bit positions
    localparam int ERR_DUP_SOURCE     = 0;
    localparam int ERR_UNKNOWN_SOURCE = 1;
    localparam int ERR_UNALIGNED      = 2;
    localparam int ERR_TIMEOUT        = 3;

    // Messages without a data payload always occupy one beat; data messages
    // occupy one beat per BEAT_BYTES of transfer, with a minimum of one.
    function automatic logic [15:0] beat_count(input logic [3:0] size,
                                               input logic [3:0] log2_beat_bytes,
                                               input logic       has_data);
        if (!has_data || (size <= log2_beat_bytes))
            return 16'd1;
        return 16'd1 << (size - log2_beat_bytes);
    endfunction

endpackage

// File: rtl/tl_inflight_tracker_if.sv
// rtl/tl_inflight_tracker_if.sv - TileLink A/D channel signals observed by the in-flight tracker
//
// Parameters: SOURCE_BITS (a_source/d_source width), ADDR_BITS (a_address width)
// Modports:
//   master - drives every channel signal (the agent producing traffic)
//   slave  - observes every channel signal (the tracker, which never drives the bus)
interface tl_inflight_tracker_if #(
    parameter int SOURCE_BITS = 7,
    parameter int ADDR_BITS   = 25
);
    logic                   a_valid;
    logic                   a_ready;
    logic [2:0]             a_opcode;
    logic [3:0]             a_size;
    logic [SOURCE_BITS-1:0] a_source;
    logic [ADDR_BITS-1:0]   a_address;

    logic                   d_valid;
    logic                   d_ready;
    logic [2:0]             d_opcode;
    logic [3:0]             d_size;
    logic [SOURCE_BITS-1:0] d_source;

    modport master (
        output a_valid, a_ready, a_opcode, a_size, a_source, a_address,
        output d_valid, d_ready, d_opcode, d_size, d_source
    );

    modport slave (
        input a_valid, a_ready, a_opcode, a_size, a_source, a_address,
        input d_valid, d_ready, d_opcode, d_size, d_source
    );
endinterface

// File: rtl/tl_inflight_tracker_beat_counter.sv
// rtl/tl_inflight_tracker_beat_counter.sv - per-channel beat counter flagging first and last beats of a message
//
// Module tl_beat_counter
// Parameters:
//   LOG2_BEAT_BYTES - log2 of data bus width in bytes
//   IS_D_CHANNEL    - 1: D opcode decode (AccessAckData carries data), 0: A decode (Put* carry data)
// Ports:
//   clock, reset_n  - clock, asynchronous active-low reset
//   fire            - handshake completed this cycle
//   opcode, size    - current beat's opcode and log2 transfer size
//   first, last     - current beat is the first / last of its message
module tl_beat_counter
    import tl_trk_pkg::*;
#(
    parameter int LOG2_BEAT_BYTES = 2,
    parameter bit IS_D_CHANNEL    = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       fire,
    input  logic [2:0] opcode,
    input  logic [3:0] size,
    output logic       first,
    output logic       last
);

    logic [15:0] beat_idx;
    logic [15:0] beats;
    logic        has_data;

    always_comb begin
        if (IS_D_CHANNEL)
            has_data = (opcode == OP_ACCESS_ACK_DATA);
        else
            has_data = (opcode == OP_PUT_FULL_DATA) || (opcode == OP_PUT_PARTIAL_DATA);
    end

    assign beats = beat_count(size, 4'(LOG2_BEAT_BYTES), has_data);
    assign first = (beat_idx == 16'd0);
    assign last  = (beat_idx == (beats - 16'd1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            beat_idx <= 16'd0;
        else if (fire)
            beat_idx <= last ? 16'd0 : beat_idx + 16'd1;
    end

endmodule

// File: rtl/tl_inflight_tracker.sv
// rtl/tl_inflight_tracker.sv - tracks outstanding TileLink source IDs and flags protocol errors
//
// Optional feature macro: TL_INFLIGHT_TIMEOUT_EN (enables the no-response watchdog driving err[3])
// Parameters: SOURCE_BITS, ADDR_BITS, BEAT_BYTES, TIMEOUT_CYCLES
// Ports:
//   clock, reset_n  - clock, asynchronous active-low reset
//   bus             - observed A/D channel signals (slave modport)
//   err_clear       - synchronous clear of the sticky err flags
//   inflight_count  - number of source IDs currently outstanding
//   err             - sticky flags: [0] duplicate A source, [1] D for unknown source,
//                     [2] A address unaligned to a_size, [3] response timeout
module tl_inflight_tracker
    import tl_trk_pkg::*;
#(
    parameter int SOURCE_BITS    = 7,
    parameter int ADDR_BITS      = 25,
    parameter int BEAT_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clock,
    input  logic                    reset_n,
    tl_inflight_tracker_if.slave    bus,
    input  logic                    err_clear,
    output logic [SOURCE_BITS:0]    inflight_count,
    output logic [3:0]              err
);

    localparam int NUM_IDS         = 1 << SOURCE_BITS;
    localparam int LOG2_BEAT_BYTES = $clog2(BEAT_BYTES);

    logic               a_fire;
    logic               d_fire;
    logic               a_first;
    logic               a_last;
    logic               d_first;
    logic               d_last;
    logic               a_first_fire;
    logic               d_last_fire;
    logic               d_known;
    logic               d_clear_ok;
    logic               same_id_clear;
    logic               count_inc;
    logic               count_dec;
    logic [ADDR_BITS-1:0] align_mask;
    logic [3:0]         err_set;
    logic [NUM_IDS-1:0] pending;

    assign a_fire = bus.a_valid & bus.a_ready;
    assign d_fire = bus.d_valid & bus.d_ready;

    tl_beat_counter #(
        .LOG2_BEAT_BYTES (LOG2_BEAT_BYTES),
        .IS_D_CHANNEL    (1'b0)
    ) u_a_beats (
        .clock   (clock),
        .reset_n (reset_n),
        .fire    (a_fire),
        .opcode  (bus.a_opcode),
        .size    (bus.a_size),
        .first   (a_first),
        .last    (a_last)
    );

    tl_beat_counter #(
        .LOG2_BEAT_BYTES (LOG2_BEAT_BYTES),
        .IS_D_CHANNEL    (1'b1)
    ) u_d_beats (
        .clock   (clock),
        .reset_n (reset_n),
        .fire    (d_fire),
        .opcode  (bus.d_opcode),
        .size    (bus.d_size),
        .first   (d_first),
        .last    (d_last)
    );

    assign a_first_fire = a_fire & a_first;
    assign d_last_fire  = d_fire & d_last;

    // D is always judged against the bitmap as it stood at the start of the cycle.
    assign d_known       = pending[bus.d_source];
    assign d_clear_ok    = d_last_fire & d_known;
    assign same_id_clear = d_clear_ok & (bus.d_source == bus.a_source);

    // A count increment happens whenever the A first beat leaves its bit set where it
    // was clear, or re-sets a bit that D is clearing in the same cycle.
    assign count_inc = a_first_fire & (~pending[bus.a_source] | same_id_clear);
    assign count_dec = d_clear_ok;

    // Low a_size bits of the address must be zero; sizes beyond the address width
    // simply check the whole address.
    assign align_mask = ~({ADDR_BITS{1'b1}} << bus.a_size);

`ifdef TL_INFLIGHT_TIMEOUT_EN
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_BITS-1:0] watchdog;
    logic               timeout_hit;

    assign timeout_hit = (watchdog == WD_BITS'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            watchdog <= '0;
        else if (d_fire || (inflight_count == '0))
            watchdog <= '0;
        else if (!timeout_hit)
            watchdog <= watchdog + WD_BITS'(1);
    end
`else
    logic timeout_hit;

    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        err_set                     = 4'b0000;
        err_set[ERR_DUP_SOURCE]     = a_first_fire & pending[bus.a_source] & ~same_id_clear;
        err_set[ERR_UNKNOWN_SOURCE] = d_last_fire & ~d_known;
        err_set[ERR_UNALIGNED]      = a_first_fire & ((bus.a_address & align_mask) != '0);
        err_set[ERR_TIMEOUT]        = timeout_hit;
    end

    // Clear precedes set so an A first beat re-marks an ID that D retires in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            if (d_clear_ok)
                pending[bus.d_source] <= 1'b0;
            if (a_first_fire)
                pending[bus.a_source] <= 1'b1;
        end
    end

    // Tracks popcount(pending) incrementally; it cannot exceed NUM_IDS because each
    // increment corresponds to a bit that becomes (or stays, net of a clear) set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            inflight_count <= '0;
        else
            inflight_count <= inflight_count
                            + (SOURCE_BITS+1)'(count_inc)
                            - (SOURCE_BITS+1)'(count_dec);
    end

    // A new error in the clearing cycle survives the clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            err <= 4'b0000;
        else if (err_clear)
            err <= err_set;
        else
            err <= err | err_set;
    end

endmodule

// File: tb/tb_tl_inflight_tracker.sv
// tb/tb_tl_inflight_tracker.sv - directed self-checking bench for tl_inflight_tracker
module tb_tl_inflight_tracker;

    localparam int SOURCE_BITS    = 7;
    localparam int ADDR_BITS      = 25;
    localparam int BEAT_BYTES     = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic                 clock;
    logic                 reset_n;
    logic                 err_clear;
    logic [SOURCE_BITS:0] inflight_count;
    logic [3:0]           err;

    int tests_run;
    int tests_failed;

    tl_inflight_tracker_if #(.SOURCE_BITS(SOURCE_BITS), .ADDR_BITS(ADDR_BITS)) bus ();

    tl_inflight_tracker #(
        .SOURCE_BITS    (SOURCE_BITS),
        .ADDR_BITS      (ADDR_BITS),
        .BEAT_BYTES     (BEAT_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus            (bus.slave),
        .err_clear      (err_clear),
        .inflight_count (inflight_count),
        .err            (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle of stimulus; inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic av, input logic [2:0] aop, input logic [3:0] asz,
                        input logic [6:0] asrc, input logic [24:0] aaddr,
                        input logic dv, input logic [2:0] dop, input logic [3:0] dsz,
                        input logic [6:0] dsrc, input logic clr);
        bus.a_valid   = av;
        bus.a_opcode  = aop;
        bus.a_size    = asz;
        bus.a_source  = asrc;
        bus.a_address = aaddr;
        bus.d_valid   = dv;
        bus.d_opcode  = dop;
        bus.d_size    = dsz;
        bus.d_source  = dsrc;
        err_clear     = clr;
        @(posedge clock);
        #1;
        bus.a_valid = 1'b0;
        bus.d_valid = 1'b0;
        err_clear   = 1'b0;
    endtask

    task automatic a_only(input logic [2:0] op, input logic [3:0] sz, input logic [6:0] src, input logic [24:0] addr);
        step(1'b1, op, sz, src, addr, 1'b0, 3'd0, 4'd0, 7'd0, 1'b0);
    endtask

    task automatic d_only(input logic [2:0] op, input logic [3:0] sz, input logic [6:0] src);
        step(1'b0, 3'd4, 4'd0, 7'd0, 25'd0, 1'b1, op, sz, src, 1'b0);
    endtask

    task automatic clr_err();
        step(1'b0, 3'd4, 4'd0, 7'd0, 25'd0, 1'b0, 3'd0, 4'd0, 7'd0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 3'd4, 4'd0, 7'd0, 25'd0, 1'b0, 3'd0, 4'd0, 7'd0, 1'b0);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset_n       = 1'b0;
        err_clear     = 1'b0;
        bus.a_valid   = 1'b0;
        bus.a_ready   = 1'b1;
        bus.a_opcode  = 3'd4;
        bus.a_size    = 4'd0;
        bus.a_source  = '0;
        bus.a_address = '0;
        bus.d_valid   = 1'b0;
        bus.d_ready   = 1'b1;
        bus.d_opcode  = 3'd0;
        bus.d_size    = 4'd0;
        bus.d_source  = '0;

        #1;
        check("reset_count", 32'(inflight_count), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle();

        // Get src 5 then AccessAck src 5
        a_only(3'd4, 4'd2, 7'd5, 25'h40);
        check("get5_count", 32'(inflight_count), 32'd1);
        check("get5_err", 32'(err), 32'd0);
        d_only(3'd0, 4'd2, 7'd5);
        check("ack5_count", 32'(inflight_count), 32'd0);
        check("ack5_err", 32'(err), 32'd0);

        // 4-beat PutFullData src 3, then duplicate Get src 3
        a_only(3'd0, 4'd4, 7'd3, 25'h100);
        check("put3_b1_count", 32'(inflight_count), 32'd1);
        check("put3_b1_err", 32'(err), 32'd0);
        a_only(3'd0, 4'd4, 7'd3, 25'h104);
        a_only(3'd0, 4'd4, 7'd3, 25'h108);
        a_only(3'd0, 4'd4, 7'd3, 25'h10C);
        check("put3_b4_count", 32'(inflight_count), 32'd1);
        check("put3_b4_err", 32'(err), 32'd0);
        a_only(3'd4, 4'd2, 7'd3, 25'h200);
        check("dup3_err", 32'(err), 32'b0001);
        check("dup3_count", 32'(inflight_count), 32'd1);
        d_only(3'd0, 4'd2, 7'd3);
        check("ack3_count", 32'(inflight_count), 32'd0);
        clr_err();
        check("clr_after_dup", 32'(err), 32'd0);

        // D for an unknown source
        d_only(3'd1, 4'd2, 7'd9);
        check("unk9_err", 32'(err), 32'b0010);
        check("unk9_count", 32'(inflight_count), 32'd0);
        // err_clear together with a new unaligned error: new error survives, old one clears
        step(1'b1, 3'd4, 4'd1, 7'd20, 25'h41, 1'b0, 3'd0, 4'd0, 7'd0, 1'b1);
        check("clr_vs_new_err", 32'(err), 32'b0100);
        check("get20_count", 32'(inflight_count), 32'd1);
        clr_err();
        check("clr_only", 32'(err), 32'd0);
        d_only(3'd0, 4'd1, 7'd20);
        check("ack20_count", 32'(inflight_count), 32'd0);

        // Unaligned Get, then same-cycle A/D on one ID and on different IDs
        a_only(3'd4, 4'd2, 7'd8, 25'h42);
        check("unaligned_err", 32'(err), 32'b0100);
        check("get8_count", 32'(inflight_count), 32'd1);
        clr_err();
        a_only(3'd4, 4'd2, 7'd7, 25'h80);
        check("get7_count", 32'(inflight_count), 32'd2);
        step(1'b1, 3'd4, 4'd2, 7'd7, 25'h80, 1'b1, 3'd0, 4'd2, 7'd7, 1'b0);
        check("same_id_err", 32'(err), 32'd0);
        check("same_id_count", 32'(inflight_count), 32'd2);
        step(1'b1, 3'd4, 4'd2, 7'd11, 25'hC0, 1'b1, 3'd0, 4'd2, 7'd8, 1'b0);
        check("diff_id_count", 32'(inflight_count), 32'd2);
        check("diff_id_err", 32'(err), 32'd0);
        d_only(3'd0, 4'd2, 7'd7);
        d_only(3'd0, 4'd2, 7'd11);
        check("drain_count", 32'(inflight_count), 32'd0);
        check("drain_err", 32'(err), 32'd0);

        // Valid without ready does not fire
        bus.a_ready = 1'b0;
        a_only(3'd4, 4'd2, 7'd20, 25'h0);
        check("no_ready_a_count", 32'(inflight_count), 32'd0);
        bus.a_ready = 1'b1;
        bus.d_ready = 1'b0;
        d_only(3'd0, 4'd2, 7'd21);
        check("no_ready_d_err", 32'(err), 32'd0);
        bus.d_ready = 1'b1;

        // Highest source ID
        a_only(3'd4, 4'd2, 7'd127, 25'h1FFFFFC);
        check("get127_count", 32'(inflight_count), 32'd1);
        d_only(3'd0, 4'd2, 7'd127);
        check("ack127_count", 32'(inflight_count), 32'd0);
        check("src127_err", 32'(err), 32'd0);

        // Response watchdog
        a_only(3'd4, 4'd2, 7'd1, 25'h0);
        check("get1_count", 32'(inflight_count), 32'd1);
        for (int i = 0; i < 10; i++) idle();
        check("wd_early_err", 32'(err), 32'd0);
        for (int i = 0; i < 10; i++) idle();
`ifdef TL_INFLIGHT_TIMEOUT_EN
        check("wd_timeout_err", 32'(err), 32'b1000);
`else
        check("wd_timeout_err", 32'(err), 32'b0000);
`endif
        d_only(3'd0, 4'd2, 7'd1);
        clr_err();
        check("wd_clear_err", 32'(err), 32'd0);
        check("wd_count", 32'(inflight_count), 32'd0);

        // Reset in the middle of a 4-beat AccessAckData
        a_only(3'd4, 4'd4, 7'd2, 25'h0);
        d_only(3'd1, 4'd4, 7'd2);
        d_only(3'd1, 4'd4, 7'd2);
        check("midburst_count", 32'(inflight_count), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_count", 32'(inflight_count), 32'd0);
        check("async_reset_err", 32'(err), 32'd0);
        #2;
        reset_n = 1'b1;
        d_only(3'd0, 4'd2, 7'd0);
        check("post_reset_unk_err", 32'(err), 32'b0010);
        check("post_reset_count", 32'(inflight_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
